// File: rtl/pwm_moto_decoder.sv
// rtl/pwm_moto_decoder.sv - recovers direction, period and high time from motor drive lines
module pwm_moto_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             moto_a,
    input  logic             moto_b,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             direction,
    output logic             running,
    output logic             stalled,
    output logic             fault
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A timeout beyond the counter range is clamped so a saturated counter still trips it.
    localparam logic [CNT_W-1:0] TO_VAL =
        (longint'(TIMEOUT) >= ((longint'(1) << CNT_W) - 1)) ? CNT_MAX : CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             a1, a2, b1, b2, pwm_d;
    logic             dir_cur;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic             pwm, rise, fall, dual, timeout;

    always_comb begin
        pwm     = a2 | b2;
        rise    = pwm & ~pwm_d;
        fall    = ~pwm & pwm_d;
        dual    = a2 & b2;
        timeout = (per_cnt >= TO_VAL);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            a1      <= 1'b0;
            a2      <= 1'b0;
            b1      <= 1'b0;
            b2      <= 1'b0;
            pwm_d   <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            a1    <= moto_a;
            a2    <= a1;
            b1    <= moto_b;
            b2    <= b1;
            pwm_d <= pwm;
            if (dual) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (per_cnt != CNT_MAX)
                    per_cnt <= per_cnt + 1'b1;
                // pwm stays low from the fall until the next rise, so hi_cnt holds there.
                if (pwm && hi_cnt != CNT_MAX)
                    hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            dir_cur    <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            direction  <= 1'b0;
            running    <= 1'b0;
            stalled    <= 1'b0;
            fault      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            fault      <= 1'b0;
            if (dual) begin
                fault   <= 1'b1;
                running <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            dir_cur <= b2;
                            stalled <= 1'b0;
                            state   <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (timeout) begin
                            stalled <= 1'b1;
                            running <= 1'b0;
                            state   <= IDLE;
                        end else if (fall) begin
                            state <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state <= HIGH;
                            if (b2 == dir_cur) begin
                                meas_valid <= 1'b1;
                                period     <= per_cnt;
                                high_time  <= hi_cnt;
                                direction  <= dir_cur;
                                running    <= 1'b1;
                            end else begin
                                dir_cur <= b2;
                            end
                        end else if (timeout) begin
                            stalled <= 1'b1;
                            running <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_moto_decoder.sv
// tb/tb_pwm_moto_decoder.sv - bench for pwm_moto_decoder against a sample-level reference model
module tb_pwm_moto_decoder;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int CMAX    = 65535;

    typedef struct packed {
        logic        valid;
        logic [15:0] per;
        logic [15:0] hi;
        logic        dir;
        logic        run;
        logic        stl;
        logic        flt;
    } obs_t;

    logic             sys_clk, sys_rst, moto_a, moto_b;
    logic             meas_valid, direction, running, stalled, fault;
    logic [CNT_W-1:0] period, high_time;

    pwm_moto_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .moto_a    (moto_a),
        .moto_b    (moto_b),
        .meas_valid(meas_valid),
        .period    (period),
        .high_time (high_time),
        .direction (direction),
        .running   (running),
        .stalled   (stalled),
        .fault     (fault)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   fault_seen = 0;
    int   meas_seen = 0;
    obs_t q[$];

    // Reference model: works on the sampled line values, one sample per clock edge.
    int   m_n, m_rise_n, m_hi;
    bit   m_track, m_dir, m_prev;
    obs_t m_out;

    function automatic obs_t dut_obs();
        obs_t o;
        o.valid = meas_valid;
        o.per   = period;
        o.hi    = high_time;
        o.dir   = direction;
        o.run   = running;
        o.stl   = stalled;
        o.flt   = fault;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_rise_n = 0; m_hi = 0;
        m_track = 0; m_dir = 0; m_prev = 0;
        m_out = '0;
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic model_step(input bit a, input bit b);
        bit pwm, rise;
        int span, hi;
        pwm  = a | b;
        rise = pwm && !m_prev;
        span = (m_n - m_rise_n > CMAX) ? CMAX : m_n - m_rise_n;
        hi   = (m_hi > CMAX) ? CMAX : m_hi;
        m_out.valid = 0;
        m_out.flt   = 0;
        if (a && b) begin
            m_out.flt = 1;
            m_out.run = 0;
            m_track   = 0;
        end else if (rise) begin
            if (m_track && b == m_dir) begin
                m_out.valid = 1;
                m_out.per   = 16'(span);
                m_out.hi    = 16'(hi);
                m_out.dir   = m_dir;
                m_out.run   = 1;
            end else begin
                m_dir     = b;
                m_track   = 1;
                m_out.stl = 0;
            end
        end else if (m_track && span >= TIMEOUT) begin
            m_track   = 0;
            m_out.stl = 1;
            m_out.run = 0;
        end
        if (rise && !(a && b)) begin
            m_rise_n = m_n;
            m_hi     = 1;
        end else if (pwm) begin
            m_hi++;
        end
        m_prev = pwm;
        m_n++;
    endtask

    task automatic step(input bit a, input bit b);
        obs_t e;
        moto_a = a;
        moto_b = b;
        @(posedge sys_clk);
        model_step(a, b);
        q.push_back(m_out);
        #1;
        e = q.pop_front();
        chk("cycle", 64'(dut_obs()), 64'(e));
        if (fault) fault_seen++;
        if (meas_valid) meas_seen++;
    endtask

    task automatic seg(input bit dir, input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                step(dir ? 1'b0 : (i < hi), dir ? (i < hi) : 1'b0);
    endtask

    task automatic hold(input bit dir, input bit v, input int n);
        for (int i = 0; i < n; i++)
            step(dir ? 1'b0 : v, dir ? v : 1'b0);
    endtask

    task automatic apply_reset();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("async_reset", 64'(dut_obs()), 64'd0);
        moto_a = 1'b0;
        moto_b = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int kind, per;
        sys_rst = 1'b1;
        moto_a  = 1'b0;
        moto_b  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_state", 64'(dut_obs()), 64'd0);
        sys_rst = 1'b0;
        model_reset();

        // Forward, period 2
        seg(1'b0, 2, 1, 8);
        chk("fwd2_period", 64'(period), 64'd2);
        chk("fwd2_high", 64'(high_time), 64'd1);
        chk("fwd2_dir", 64'(direction), 64'd0);
        chk("fwd2_running", 64'(running), 64'd1);

        // Reverse, period 3: pattern 0,1,1
        for (int p = 0; p < 6; p++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
        end
        chk("rev3_period", 64'(period), 64'd3);
        chk("rev3_high", 64'(high_time), 64'd2);
        chk("rev3_dir", 64'(direction), 64'd1);

        // Direction change
        seg(1'b0, 3, 1, 5);
        meas_seen = 0;
        seg(1'b1, 3, 1, 1);
        step(1'b0, 1'b0);
        chk("dirchg_no_meas", 64'(meas_seen), 64'd0);
        seg(1'b1, 3, 1, 3);
        chk("dirchg_period", 64'(period), 64'd3);
        chk("dirchg_dir", 64'(direction), 64'd1);

        // Stall with line held high, then resume
        seg(1'b0, 2, 1, 5);
        hold(1'b0, 1'b1, TIMEOUT + 8);
        chk("stall_flag", 64'(stalled), 64'd1);
        chk("stall_running", 64'(running), 64'd0);
        chk("stall_period", 64'(period), 64'd2);
        chk("stall_high", 64'(high_time), 64'd1);
        seg(1'b0, 2, 1, 4);
        chk("resume_stall_clear", 64'(stalled), 64'd0);

        // Single-cycle fault mid-period
        seg(1'b0, 6, 3, 3);
        step(1'b1, 1'b0);
        fault_seen = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("fault_pulses", 64'(fault_seen), 64'd1);
        chk("fault_running", 64'(running), 64'd0);
        meas_seen = 0;
        seg(1'b0, 3, 1, 3);
        chk("fault_recover_meas", 64'(meas_seen), 64'd2);

        // Reset mid-HIGH
        seg(1'b0, 4, 2, 3);
        step(1'b1, 1'b0);
        apply_reset();
        meas_seen = 0;
        seg(1'b0, 2, 1, 3);
        chk("post_reset_meas", 64'(meas_seen), 64'd1);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b1, 1'b1);
                step(1'b0, 1'b0);
            end else if (kind == 1) begin
                hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     TIMEOUT + int'($urandom_range(0, 10)) - 4);
            end else if (kind == 2 && it % 4 == 0) begin
                apply_reset();
            end else begin
                per = $urandom_range(2, 12);
                seg(1'($urandom_range(0, 1)), per, $urandom_range(1, per - 1),
                    $urandom_range(1, 6));
            end
        end
        hold(1'b0, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
